// File: rtl/rr_mux_arbiter_if.sv
// rtl/rr_mux_arbiter_if.sv - producer/consumer handshake bundle for rr_mux_arbiter
interface rr_mux_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int N     = 3
);
  localparam int SEL_W = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - N-input arbitrating mux, fixed-priority or round-robin grant
// feeding a single registered valid/ready output stage.
module rr_mux_arbiter #(
  parameter int WIDTH = 32,
  parameter int N     = 3,
  parameter int MODE  = 1
) (
  input logic             clk,
  input logic             rst,
  rr_mux_arbiter_if.slave bus
);
  localparam int SEL_W = $clog2(N);

  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;
  logic             r_valid;

  logic [SEL_W-1:0] w_grant;
  logic [SEL_W:0]   w_sum;
  logic [SEL_W-1:0] w_cand;
  logic             w_found;
  logic             w_any;
  logic             w_load_en;
  logic             w_take;
  logic [N-1:0]     w_ready;

  assign w_any     = |bus.in_valid;
  // Gated by rst so no handshake can complete while reset is held.
  assign w_load_en = !rst && (!r_valid || bus.out_ready);
  assign w_take    = w_load_en && w_any;

  // Search starts at r_ptr and wraps modulo N; in fixed-priority mode r_ptr stays 0.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (SEL_W+1)'(k);
      if (w_sum >= (SEL_W+1)'(N)) begin
        w_sum = w_sum - (SEL_W+1)'(N);
      end
      w_cand = w_sum[SEL_W-1:0];
      if (!w_found && bus.in_valid[w_cand]) begin
        w_grant = w_cand;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_take) begin
      w_ready[w_grant] = 1'b1;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_data  = r_data;
  assign bus.out_sel   = r_sel;
  assign bus.out_valid = r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_take) begin
      r_data  <= bus.in_data[w_grant*WIDTH +: WIDTH];
      r_sel   <= w_grant;
      r_valid <= 1'b1;
      if (MODE == 1) begin
        r_ptr <= (w_grant == SEL_W'(N-1)) ? '0 : w_grant + 1'b1;
      end
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Parametrised N-input, WIDTH-bit arbitrating multiplexer with a registered output stage and valid/ready handshakes on every port. It generalises the static 3:1 select mux. The select is produced internally by a fixed-priority or round-robin arbiter rather than supplied by decode logic. It sits where several producers contend for one consumer: ALU, load unit and CSR results merging into a shared writeback port in the multi-cycle and pipelined cores.

## Interface
- WIDTH, 32: data width of every channel.
- N, 3: number of input channels, N >= 2.
- MODE, 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
- SEL_W, $clog2(N): width of the grant index (derived, do not override).

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel request.
- in_ready  out  N  per-channel accept; at most one bit set per cycle.
- out_data  out  WIDTH  registered selected data.
- out_sel  out  SEL_W  registered index of the channel that supplied out_data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.

## Operation
- Transfer on an input occurs when in_valid[i] && in_ready[i]. Transfer on the output occurs when out_valid && out_ready.
- load_en = !out_valid || out_ready, meaning the output register is empty or is draining this cycle.
- The grant is combinational over in_valid:
  - MODE 0: grant goes to the lowest index i with in_valid[i].
  - MODE 1: grant goes to the first valid index searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- in_ready[g] = load_en && any(in_valid) for the granted index g. All other in_ready bits are 0. in_ready never depends on a channel that is not valid.
- On an input transfer from channel g, at the next edge:
  - out_data <= slice g.
  - out_sel <= g.
  - out_valid <= 1.
  - In MODE 1 only, ptr <= (g == N-1) ? 0 : g+1.
- On an output transfer with no input transfer in the same cycle: out_valid <= 0. out_data and out_sel hold their last values.
- When the output register is full and out_ready=0, the register and ptr are frozen and all in_ready bits are 0.
- ptr changes only on an input transfer. It never changes while idle or stalled.
- Producers must hold in_data and in_valid stable until accepted. The block does not re-sample a channel that has not been accepted.
- Channel data is passed through unmodified. There is no width conversion or sign handling.

## Timing
- Reset values, applied asynchronously on rst=1 and released synchronously by design: out_valid=0, out_data=0, out_sel=0, ptr=0, so all in_ready bits are 0 while rst is high.
- Latency: input accept at edge k, data visible on out_data/out_valid after edge k.
- Throughput: one word per cycle sustained when out_ready=1 (simultaneous drain and load).
- Combinational paths: in_valid and out_ready to in_ready. There is no combinational path from any input to out_data, out_valid or out_sel.
- Simultaneous requests: exactly one channel is accepted per cycle. The others see in_ready=0 and must keep in_valid asserted.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, each channel is served exactly once in every N consecutive cycles.
- Reset mid-operation: a held word is dropped, out_valid goes 0 immediately (asynchronous), and ptr returns to 0. An in-flight handshake in that cycle counts as not accepted.
- N that is not a power of two: grant and ptr never take values >= N.

## Test plan
- Reset: assert rst mid-stream with out_valid=1 and out_data=0xDEADBEEF -> out_valid=0, out_data=0, out_sel=0 without waiting for a clock edge. The first grant after release goes to channel 0 when all channels are valid.
- Single channel, MODE 1, N=3: only ch1 valid with data 0x00000011, out_ready=1 -> in_ready=3'b010. Next cycle out_data=0x11, out_sel=1, out_valid=1. ptr becomes 2.
- Round-robin, N=3: all valid continuously with data 0xA0/0xB1/0xC2, out_ready=1 -> out_sel sequence 0,1,2,0,1,2 and out_data 0xA0,0xB1,0xC2,... one word per cycle.
- Fixed priority, MODE 0: all valid for 4 cycles -> out_sel=0 every cycle and in_ready[2:1] stay 0.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles, all inputs valid -> in_ready=0, out_data and ptr unchanged. Raising out_ready gives a drain and a new load in the same cycle, and out_valid stays 1.
- Drain without refill: output full, out_ready=1, no in_valid -> out_valid=0 next cycle, out_data retains its last value.
